// File: rtl/pipe_pkg.sv
// Shared pipeline types for hazard/forwarding control: forward-select encoding,
// in-flight destination slot, and the slot-match helper.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
    logic             wr;
  } inflight_t;

  localparam inflight_t SLOT_EMPTY = '{valid: 1'b0, rd: REG_ZERO, is_load: 1'b0, wr: 1'b0};

  // x0 is hardwired, so it never creates a dependency
  function automatic logic slot_match(input logic [REG_W-1:0] src, input logic used,
                                      input inflight_t s);
    return used && (src != REG_ZERO) && s.valid && s.wr && (s.rd == src);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source RAW check against the EX/MEM/WB slots: hazard flag, ID-stage
// forward select and the EX-stage select the operand needs one cycle later.
module hazard_src_match
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_used,
  input  logic             i_early,
  input  inflight_t        i_ex,
  input  inflight_t        i_mem,
  input  inflight_t        i_wb,
  output logic             o_hazard,
  output fwd_sel_t         o_id_fwd,
  output fwd_sel_t         o_ex_fwd
);

  logic w_m_ex, w_m_mem, w_m_wb;

  assign w_m_ex  = slot_match(i_src, i_used, i_ex);
  assign w_m_mem = slot_match(i_src, i_used, i_mem);
  assign w_m_wb  = slot_match(i_src, i_used, i_wb);

  // Youngest match wins in every decision below
  always_comb begin
    o_hazard = 1'b0;
    o_id_fwd = FWD_RF;
    o_ex_fwd = FWD_RF;
    if (i_early) begin
      o_hazard = w_m_ex || (w_m_mem && i_mem.is_load);
    end else begin
      o_hazard = w_m_ex && i_ex.is_load;
    end
    if (i_early && !w_m_ex) begin
      if (w_m_mem) begin
        o_id_fwd = i_mem.is_load ? FWD_RF : FWD_MEM;
      end else if (w_m_wb) begin
        o_id_fwd = FWD_WB;
      end else begin
        o_id_fwd = FWD_RF;
      end
    end else begin
      o_id_fwd = FWD_RF;
    end
    // A WB producer is in the regfile by the time the operand reaches EX
    if (w_m_ex) begin
      o_ex_fwd = i_ex.is_load ? FWD_RF : FWD_MEM;
    end else if (w_m_mem) begin
      o_ex_fwd = FWD_WB;
    end else begin
      o_ex_fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline.
// Optional stall counter port/logic enabled by HAZARD_PERF_EN.
module id_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_rs1,
  input  logic [$clog2(NREG)-1:0] id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic                    id_early_use,
  input  logic [$clog2(NREG)-1:0] id_rd,
  input  logic                    id_rd_wr,
  input  logic                    id_is_load,
  input  logic                    id_redirect,
  input  logic                    mem_busy,
  output logic                    stall_id,
  output logic                    if_flush,
  output logic [1:0]              id_fwd_a,
  output logic [1:0]              id_fwd_b,
  output logic [1:0]              ex_fwd_a,
  output logic [1:0]              ex_fwd_b,
  output logic                    ex_bubble
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cycles
`endif
);

  inflight_t r_ex, r_mem, r_wb;
  fwd_sel_t  r_ex_fwd_a, r_ex_fwd_b;
  logic      r_ex_bubble;

  logic      w_haz_a, w_haz_b, w_hazard, w_stall;
  fwd_sel_t  w_id_fwd_a, w_id_fwd_b, w_ex_fwd_a, w_ex_fwd_b;

  hazard_src_match u_match_rs1 (
    .i_src    (id_rs1),
    .i_used   (id_rs1_used),
    .i_early  (id_early_use),
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .o_hazard (w_haz_a),
    .o_id_fwd (w_id_fwd_a),
    .o_ex_fwd (w_ex_fwd_a)
  );

  hazard_src_match u_match_rs2 (
    .i_src    (id_rs2),
    .i_used   (id_rs2_used),
    .i_early  (id_early_use),
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .o_hazard (w_haz_b),
    .o_id_fwd (w_id_fwd_b),
    .o_ex_fwd (w_ex_fwd_b)
  );

  assign w_hazard  = id_valid && (w_haz_a || w_haz_b);
  assign w_stall   = mem_busy || w_hazard;
  assign stall_id  = w_stall;
  assign if_flush  = id_valid && id_redirect && !w_stall;
  assign id_fwd_a  = w_id_fwd_a;
  assign id_fwd_b  = w_id_fwd_b;
  assign ex_fwd_a  = r_ex_fwd_a;
  assign ex_fwd_b  = r_ex_fwd_b;
  assign ex_bubble = r_ex_bubble;

  // Slot shift; mem_busy freezes everything, a hazard injects an EX bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex        <= SLOT_EMPTY;
      r_mem       <= SLOT_EMPTY;
      r_wb        <= SLOT_EMPTY;
      r_ex_fwd_a  <= FWD_RF;
      r_ex_fwd_b  <= FWD_RF;
      r_ex_bubble <= 1'b1;
    end else if (!mem_busy) begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_hazard) begin
        r_ex        <= SLOT_EMPTY;
        r_ex_fwd_a  <= FWD_RF;
        r_ex_fwd_b  <= FWD_RF;
        r_ex_bubble <= 1'b1;
      end else begin
        r_ex        <= '{valid: id_valid, rd: id_rd, is_load: id_is_load, wr: id_rd_wr};
        r_ex_fwd_a  <= id_valid ? w_ex_fwd_a : FWD_RF;
        r_ex_fwd_b  <= id_valid ? w_ex_fwd_b : FWD_RF;
        r_ex_bubble <= !id_valid;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;

  // Stall cycle counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: combinational outputs checked each cycle,
// registered EX outputs queued as expectations and compared after the edge.
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_early_use, id_rd_wr, id_is_load;
  logic       id_redirect, mem_busy;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_id, if_flush, ex_bubble;
  logic [1:0] id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       bub;
    logic [1:0] ea;
    logic [1:0] eb;
    bit         chkf;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_early_use (id_early_use),
    .id_rd        (id_rd),
    .id_rd_wr     (id_rd_wr),
    .id_is_load   (id_is_load),
    .id_redirect  (id_redirect),
    .mem_busy     (mem_busy),
    .stall_id     (stall_id),
    .if_flush     (if_flush),
    .id_fwd_a     (id_fwd_a),
    .id_fwd_b     (id_fwd_b),
    .ex_fwd_a     (ex_fwd_a),
    .ex_fwd_b     (ex_fwd_b),
    .ex_bubble    (ex_bubble)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic e,
                     input logic [4:0] rd, input logic wr, input logic ld,
                     input logic rdr, input logic mb);
    id_valid = v;  id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_early_use = e; id_rd = rd; id_rd_wr = wr; id_is_load = ld;
    id_redirect = rdr; mem_busy = mb;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One pipeline cycle: starts at negedge with inputs already driven
  task automatic cyc(input string tag, input logic e_st, input logic e_fl,
                     input logic [1:0] e_ia, input logic [1:0] e_ib,
                     input logic e_bub, input logic [1:0] e_ea, input logic [1:0] e_eb,
                     input bit chkf);
    exp_t e;
    #2;
    chk({tag, ".stall"},    {1'b0, stall_id}, {1'b0, e_st});
    chk({tag, ".flush"},    {1'b0, if_flush}, {1'b0, e_fl});
    chk({tag, ".id_fwd_a"}, id_fwd_a, e_ia);
    chk({tag, ".id_fwd_b"}, id_fwd_b, e_ib);
    sb_q.push_back('{bub: e_bub, ea: e_ea, eb: e_eb, chkf: chkf});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".ex_bubble"}, {1'b0, ex_bubble}, {1'b0, e.bub});
    if (e.chkf) begin
      chk({tag, ".ex_fwd_a"}, ex_fwd_a, e.ea);
      chk({tag, ".ex_fwd_b"}, ex_fwd_b, e.eb);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      nop();
      cyc("drain", 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    nop();
    #1;
    chk("rst.stall",     {1'b0, stall_id},  2'b00);
    chk("rst.flush",     {1'b0, if_flush},  2'b00);
    chk("rst.ex_bubble", {1'b0, ex_bubble}, 2'b01);
    chk("rst.ex_fwd_a",  ex_fwd_a, 2'b00);
    chk("rst.ex_fwd_b",  ex_fwd_b, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // load x5; add x6,x5,x7
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("lu.lw",   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu.stall", 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("lu.add",  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1);
    drain();

    // add x3; sub x4,x3,x3
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("b2b.add", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("b2b.sub", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b01, 1'b1);
    drain();

    // add x1; beq x1,x2
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("ea.add",  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ea.stall", 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("ea.beq",  1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1);
    drain();

    // lw x1; beq x1,x2
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("el.lw",   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("el.stall1", 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("el.stall2", 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("el.beq",  1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drain();

    // x0 write then reads of x0
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("x0.wr",   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("x0.add",  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("x0.beq",  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drain();

    // mem_busy for 3 cycles over a load-use hazard
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("mb.lw",   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("mb.busy", 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    end
    mem_busy = 1'b0;
    cyc("mb.haz",  1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("mb.add",  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1);
    drain();

    // jal redirect, then redirect held off by a hazard
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rd.jal",  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("rd.lw",   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rd.hold1", 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("rd.hold2", 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("rd.jalr", 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drain();

    // async reset in the middle of a load-use stall
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("ar.lw",   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drv(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("ar.pre_stall", {1'b0, stall_id}, 2'b01);
    rst = 1'b1;
    #1;
    chk("ar.stall",     {1'b0, stall_id},  2'b00);
    chk("ar.ex_bubble", {1'b0, ex_bubble}, 2'b01);
    chk("ar.ex_fwd_a",  ex_fwd_a, 2'b00);
    chk("ar.ex_fwd_b",  ex_fwd_b, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    cyc("ar.add",  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
